// File: rtl/sram_controller.sv
// sram_controller: 32-bit word loads/stores over a 16-bit SRAM as LOW/HIGH halfword phases plus wait states
module sram_controller #(
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;
  localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);
  state_t      state;
  logic [2:0]  cnt;
  logic        op;
  logic [16:0] base, base_next;
  logic [31:0] wdata;
  assign base_next = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign ready = rst || state == DONE || (state == IDLE && !(wr_en || rd_en));
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op          <= 1'b0;
      base        <= '0;
      wdata       <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else
      case (state)
        IDLE: if (wr_en || rd_en) begin
          state       <= LOW;
          op          <= wr_en;
          base        <= base_next;
          wdata       <= write_data;
          sram_addr   <= {base_next, 1'b0};
          sram_dq_out <= write_data[15:0];
          sram_dq_oe  <= wr_en;
          sram_we_n   <= !wr_en;
        end
        LOW: begin
          state       <= HIGH;
          sram_addr   <= {base, 1'b1};
          sram_dq_out <= wdata[31:16];
          if (!op) read_data[15:0] <= sram_dq_in;
        end
        HIGH: begin
          state      <= WAIT;
          cnt        <= '0;
          sram_addr  <= {base, 1'b0};
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
          if (!op) read_data[31:16] <= sram_dq_in;
        end
        WAIT: begin
          cnt   <= cnt == LAST ? 3'd0 : cnt + 3'd1;
          state <= cnt == LAST ? DONE : WAIT;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller against a halfword SRAM model
module tb_sram_controller;
  logic        clk, rst, wr_en, rd_en, ready, sram_dq_oe, sram_we_n;
  logic [31:0] address, write_data, read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic [15:0] mem [64];
  int passed = 0, total = 0, strobes;
  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b1; address = '0; write_data = '0;
    for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    mem[2] <= 16'h5678; mem[3] <= 16'h1234; mem[4] <= 16'hFFFF; mem[5] <= 16'hFFFF; mem[9] <= 16'h7777;
    step; step;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_oe", 32'(sram_dq_oe), 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_addr", 32'(sram_addr), 0);
    step; rst = 1'b0; rd_en = 1'b0;
    step; wr_en = 1'b1; address = 1024; write_data = 32'hDEADBEEF; #1;
    chk("wr_c0_ready", 32'(ready), 0);
    step; wr_en = 1'b0; #1;
    chk("wr_c1_addr", 32'(sram_addr), 0);
    chk("wr_c1_dq", 32'(sram_dq_out), 32'hBEEF);
    chk("wr_c1_we_n", 32'(sram_we_n), 0);
    chk("wr_c1_oe", 32'(sram_dq_oe), 1);
    chk("wr_c1_ready", 32'(ready), 0);
    step;
    chk("wr_c2_addr", 32'(sram_addr), 1);
    chk("wr_c2_dq", 32'(sram_dq_out), 32'hDEAD);
    chk("wr_c2_we_n", 32'(sram_we_n), 0);
    chk("wr_c2_ready", 32'(ready), 0);
    step;
    chk("wr_c3_we_n", 32'(sram_we_n), 1);
    chk("wr_c3_oe", 32'(sram_dq_oe), 0);
    chk("wr_c3_ready", 32'(ready), 0);
    step;
    chk("wr_c4_ready", 32'(ready), 0);
    step;
    chk("wr_c5_ready", 32'(ready), 1);
    step;
    chk("wr_c6_ready", 32'(ready), 1);
    chk("wr_mem0", 32'(mem[0]), 32'hBEEF);
    chk("wr_mem1", 32'(mem[1]), 32'hDEAD);
    chk("wr_read_data_held", read_data, 0);
    rd_en = 1'b1; address = 1028; #1;
    chk("rd_c0_ready", 32'(ready), 0);
    step; rd_en = 1'b0; #1;
    chk("rd_c1_addr", 32'(sram_addr), 2);
    chk("rd_c1_we_n", 32'(sram_we_n), 1);
    chk("rd_c1_oe", 32'(sram_dq_oe), 0);
    step;
    chk("rd_c2_addr", 32'(sram_addr), 3);
    chk("rd_c2_low", read_data, 32'h00005678);
    step;
    chk("rd_c3_data", read_data, 32'h12345678);
    step;
    chk("rd_c4_ready", 32'(ready), 0);
    step;
    chk("rd_c5_ready", 32'(ready), 1);
    chk("rd_c5_data", read_data, 32'h12345678);
    for (int c = 0; c < 12; c++) begin
      step; rd_en = 1'b1; address = 1028;
      if (c == 6) mem[2] <= 16'hCAFE;
      #1;
      chk($sformatf("b2b_ready_c%0d", c), 32'(ready), 32'(c == 5 || c == 11));
    end
    step; rd_en = 1'b0; #1;
    chk("b2b_idle_ready", 32'(ready), 1);
    chk("b2b_data", read_data, 32'h1234CAFE);
    step; wr_en = 1'b1; address = 1040; write_data = 32'h11112222; #1;
    step; wr_en = 1'b0; #1;
    chk("ab_c1_addr", 32'(sram_addr), 8);
    step; rst = 1'b1; #1;
    chk("ab_c2_we_n", 32'(sram_we_n), 0);
    chk("ab_rst_ready", 32'(ready), 1);
    step; rst = 1'b0; mem[9] <= 16'h7777; #1;
    chk("ab_we_n", 32'(sram_we_n), 1);
    chk("ab_ready", 32'(ready), 1);
    chk("ab_read_data", read_data, 0);
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      step;
      strobes += int'(!sram_we_n);
    end
    chk("ab_strobes", 32'(strobes), 0);
    chk("ab_mem9", 32'(mem[9]), 32'h7777);
    chk("ab_mem8", 32'(mem[8]), 32'h2222);
    wr_en = 1'b1; rd_en = 1'b1; address = 1032; write_data = 32'h0000AAAA; #1;
    chk("pr_c0_ready", 32'(ready), 0);
    step; wr_en = 1'b0; rd_en = 1'b0; #1;
    chk("pr_c1_we_n", 32'(sram_we_n), 0);
    step; step; step; step;
    chk("pr_c5_ready", 32'(ready), 1);
    chk("pr_mem4", 32'(mem[4]), 32'hAAAA);
    chk("pr_mem5", 32'(mem[5]), 32'h0000);
    chk("pr_read_data", read_data, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter BASE_ADDR, 1024, byte address of data memory mapped to SRAM halfword 0.
REQ-002 Parameter WAIT_CYCLES, 2, idle cycles inserted after the HIGH access phase; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  MEM-stage store request.
REQ-006 rd_en  input  1  MEM-stage load request.
REQ-007 address  input  32  byte address from EXE result.
REQ-008 write_data  input  32  store data (Val_Rm).
REQ-009 read_data  output  32  load result, registered.
REQ-010 ready  output  1  high = access complete or no request; low = pipeline must freeze.
REQ-011 sram_addr  output  18  SRAM halfword address.
REQ-012 sram_dq_out  output  16  data driven to SRAM; the top level owns the tristate.
REQ-013 sram_dq_oe  output  1  high = top level drives sram_dq_out onto the bus.
REQ-014 sram_dq_in  input  16  bus value read back from SRAM.
REQ-015 sram_we_n  output  1  SRAM write enable, active-low.

Function
REQ-016 The FSM SHALL have states IDLE, LOW, HIGH, WAIT, DONE, with a 3-bit wait counter.
- IDLE→LOW when wr_en|rd_en; else stay.
- LOW→HIGH unconditionally.
- HIGH→WAIT.
- WAIT→DONE after WAIT_CYCLES cycles in WAIT.
- DONE→IDLE.
REQ-017 On IDLE→LOW the block SHALL latch:
- op = write if wr_en, else read; wr_en wins when both are asserted.
- base = (address − BASE_ADDR)[18:2] as a 17-bit word index.
- wdata = write_data.
REQ-018 Arithmetic: the subtraction SHALL be 32-bit modulo 2^32 with no range check; bits [1:0] SHALL be ignored (word-aligned access only).
REQ-019 sram_addr SHALL be:
- {base,1'b0} in LOW;
- {base,1'b1} in HIGH;
- {base,1'b0} in all other states.
REQ-020 For a write:
- sram_dq_out SHALL be wdata[15:0] in LOW and wdata[31:16] in HIGH.
- sram_we_n SHALL be 0 and sram_dq_oe SHALL be 1 in LOW and HIGH only.
REQ-021 For a read:
- sram_we_n SHALL stay 1 and sram_dq_oe SHALL stay 0.
- read_data[15:0] SHALL load sram_dq_in at the end of LOW.
- read_data[31:16] SHALL load sram_dq_in at the end of HIGH.
REQ-022 read_data SHALL hold its value except during read loads; writes and idle cycles SHALL NOT modify it.
REQ-023 ready SHALL be combinational:
- 1 in IDLE with no request;
- 0 in IDLE with a request, and in LOW, HIGH and WAIT;
- 1 in DONE.
REQ-024 Latency: with the request first seen in cycle 0, ready SHALL go high in cycle 3+WAIT_CYCLES (cycle 5 at default), for exactly one cycle.
REQ-025 A request still asserted in the cycle after DONE SHALL be treated as a new access (back-to-back).
REQ-026 Request inputs SHALL be ignored outside IDLE, and latched values SHALL NOT change mid-access.

Reset
REQ-027 While rst=1, at the next edge:
- state=IDLE, counter=0, read_data=0, latched base/wdata/op=0;
- outputs: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-028 ready SHALL be 1 during reset regardless of wr_en/rd_en.
REQ-029 Reset mid-access SHALL abort the access: no further SRAM write strobes, and any partial read_data SHALL be cleared.

Verification
REQ-030 Reset check: hold rst 2 cycles with rd_en=1 → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0x00000000.
REQ-031 Write check: wr_en, address=1024, write_data=0xDEADBEEF →
- cycle 1: sram_addr=0, sram_dq_out=0xBEEF, sram_we_n=0;
- cycle 2: sram_addr=1, sram_dq_out=0xDEAD, sram_we_n=0;
- ready=0 in cycles 0–4, ready=1 in cycle 5.
REQ-032 Read check: SRAM model holds 0x5678 at 2 and 0x1234 at 3; rd_en, address=1028 → read_data=0x12345678 from cycle 3 onward, ready=1 in cycle 5.
REQ-033 Back-to-back check: rd_en held for 12 cycles → two complete accesses, ready=1 in cycles 5 and 11 only.
REQ-034 Abort check: rst asserted during HIGH of a write → next cycle IDLE, sram_we_n=1, ready=1; the upper halfword is not rewritten afterwards.
REQ-035 Priority check: wr_en=rd_en=1 at address 1032 with data 0x0000AAAA → SRAM halfwords 4/5 receive 0xAAAA/0x0000; read_data is unchanged from its prior value.
